div_sequencer: RTL and testbench
================================

# div_sequencer

Parametrised control sequencer for the iterative non-restoring divider. It drives the divider datapath (remainder/quotient register, adder, shifter) through load, WIDTH iterations, remainder correction and sign fix-up. It also adds three things the fixed 32-bit counter controller lacked: signed/unsigned mode, divide-by-zero early exit, and a defined busy/start handshake. It sits between the multdiv top level and the divider datapath, alongside the multiplier control.

## Interface
Parameters:
- WIDTH, 32, operand width in bits and iteration count; legal range 2..64.
- CW, $clog2(WIDTH+1), iteration counter width (derived, not overridden).

Ports:
- clock  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high; one clock; reset is synchronous and active-high.
- start  in  1  request; sampled only in IDLE.
- signed_mode  in  1  signed division when high; latched on accepted start.
- dividend_neg  in  1  dividend sign bit from datapath; latched on accepted start.
- divisor_neg  in  1  divisor sign bit from datapath; latched on accepted start.
- divisor_zero  in  1  datapath flag, divisor == 0; sampled in LOAD.
- rem_msb  in  1  sign of current partial remainder.
- sum_msb  in  1  sign of adder output this cycle.
- load  out  1  load operands (magnitudes) into datapath.
- add  out  1  adder adds divisor.
- sub  out  1  adder subtracts divisor.
- shift  out  1  shift remainder/quotient left by one, inserting q0.
- q0  out  1  quotient bit to insert.
- nop  out  1  no arithmetic this cycle.
- negate_q  out  1  two's-complement the quotient.
- negate_r  out  1  two's-complement the remainder.
- busy  out  1  operation in progress.
- ready  out  1  one-cycle result-valid pulse.
- div_by_zero  out  1  valid with ready; divisor was zero.
- count  out  CW  iterations completed.

## Operation
- States: IDLE, LOAD, ITER, CORRECT, SIGNFIX, DONE.
- IDLE: start=1 -> LOAD. Latch signed_mode, neg_q = signed_mode & (dividend_neg ^ divisor_neg), and neg_r = signed_mode & dividend_neg.
- LOAD: load=1, count cleared. If divisor_zero -> DONE with the div_by_zero flag set; else -> ITER.
- ITER: shift=1. rem_msb=0 -> sub=1; rem_msb=1 -> add=1. q0 = ~sum_msb. count increments each cycle. After the cycle in which count reaches WIDTH-1 -> CORRECT (exactly WIDTH ITER cycles).
- CORRECT: add=1 iff rem_msb=1 (remainder restore); otherwise nop=1. No shift. -> SIGNFIX.
- SIGNFIX: negate_q = neg_q and negate_r = neg_r; nop=1. -> DONE.
- DONE: ready=1; div_by_zero = latched flag. -> IDLE. The flag clears on leaving DONE.
- busy=1 in every state except IDLE.
- nop=1 whenever add, sub and load are all 0.
- add and sub are never both high. shift is only ever high in ITER.
- start while busy is ignored and not queued.
- start in the DONE cycle is ignored; accept it on the following IDLE cycle.
- Divide-by-zero result values: datapath-defined; the sequencer asserts no negate, add, sub or shift for that operation.

## Timing
- Reset values: state IDLE, count 0, latched flags 0. All outputs are 0 except nop=1.
- Reset has priority over all other inputs in every state. It aborts an operation in one cycle with no ready pulse.
- Start accepted at edge t: LOAD during cycle t+1, ITER during t+2..t+WIDTH+1, CORRECT at t+WIDTH+2, SIGNFIX at t+WIDTH+3, ready at t+WIDTH+4.
- Normal latency: WIDTH+4 cycles, fixed, independent of signed_mode.
- Divide-by-zero: ready at t+2 (LOAD then DONE).
- Back-to-back issue: minimum start-to-start spacing is WIDTH+5 cycles.
- All outputs are registered-state decodes. q0, add and sub are combinational from state plus rem_msb/sum_msb, valid within the same cycle.

## Structure
- Shared package div_pkg: state enum (IDLE..DONE) and a CW-width helper function. The multiplier control reuses the helper.
- Sub-module div_iter_counter: a CW-bit counter with sync clear, enable, and a terminal flag at WIDTH-1. It replaces the 65-bit register plus 32-bit adder counter.
- Remainder of the block: a single FSM module.

## Test plan
- WIDTH=32, unsigned, start pulse: load at cycle 1, shift high exactly 32 cycles, ready at cycle 36, busy high for cycles 1..35.
- WIDTH=8, signed, dividend_neg=1, divisor_neg=0: negate_q=1 and negate_r=1 in SIGNFIX, ready at cycle 12. Repeat with signed_mode=0: both negates 0.
- divisor_zero=1 during LOAD: ready and div_by_zero both high at cycle 2; add, sub and shift never asserted.
- ITER with rem_msb toggling 0,1,1,0: sub, add, add, sub. q0 = ~sum_msb each cycle. CORRECT with rem_msb=1 gives add=1; with rem_msb=0 gives nop=1.
- start held high continuously through an operation: exactly one operation per WIDTH+5 cycles; no second LOAD before the IDLE cycle.
- reset asserted mid-ITER at count=5: next cycle state IDLE, count 0, busy 0, ready never pulses; a fresh start then completes with normal latency.

Source files
------------

// File: rtl/div_pkg.sv
// rtl/div_pkg.sv - shared divider sequencer state encoding and counter-width helper
package div_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ITER,
    CORRECT,
    SIGNFIX,
    DONE
  } divState_t;

  // Also used by the multiplier control to size its iteration counter.
  function automatic int cntWidth(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/div_iter_counter.sv
// rtl/div_iter_counter.sv - iteration counter with sync clear, enable and last-iteration flag
module div_iter_counter #(
  parameter int WIDTH = 32,
  parameter int CW    = div_pkg::cntWidth(WIDTH)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          clear,
  input  logic          enable,
  output logic [CW-1:0] count,
  output logic          terminal
);

  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  always_ff @(posedge clock) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CW'(1);
    end
  end

  assign terminal = (count == LAST);

endmodule

// File: rtl/div_sequencer.sv
// rtl/div_sequencer.sv - control FSM for the iterative non-restoring divider datapath
module div_sequencer
  import div_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CW    = cntWidth(WIDTH)
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          start,
  input  logic          signed_mode,
  input  logic          dividend_neg,
  input  logic          divisor_neg,
  input  logic          divisor_zero,
  input  logic          rem_msb,
  input  logic          sum_msb,
  output logic          load,
  output logic          add,
  output logic          sub,
  output logic          shift,
  output logic          q0,
  output logic          nop,
  output logic          negate_q,
  output logic          negate_r,
  output logic          busy,
  output logic          ready,
  output logic          div_by_zero,
  output logic [CW-1:0] count
);

  divState_t state;
  divState_t nextState;
  logic      negQ;
  logic      negR;
  logic      zeroFlag;
  logic      cntClear;
  logic      cntEnable;
  logic      cntLast;

  div_iter_counter #(
    .WIDTH (WIDTH),
    .CW    (CW)
  ) u_iterCounter (
    .clock    (clock),
    .reset    (reset),
    .clear    (cntClear),
    .enable   (cntEnable),
    .count    (count),
    .terminal (cntLast)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= IDLE;
      negQ     <= 1'b0;
      negR     <= 1'b0;
      zeroFlag <= 1'b0;
    end else begin
      state <= nextState;
      if (state == IDLE && start) begin
        negQ <= signed_mode & (dividend_neg ^ divisor_neg);
        negR <= signed_mode & dividend_neg;
      end
      if (state == LOAD) begin
        zeroFlag <= divisor_zero;
      end
      if (state == DONE) begin
        zeroFlag <= 1'b0;
      end
    end
  end

  always_comb begin
    nextState   = state;
    load        = 1'b0;
    add         = 1'b0;
    sub         = 1'b0;
    shift       = 1'b0;
    q0          = 1'b0;
    negate_q    = 1'b0;
    negate_r    = 1'b0;
    ready       = 1'b0;
    div_by_zero = 1'b0;
    cntClear    = 1'b0;
    cntEnable   = 1'b0;
    case (state)
      IDLE: begin
        if (start) nextState = LOAD;
      end
      LOAD: begin
        load      = 1'b1;
        cntClear  = 1'b1;
        nextState = divisor_zero ? DONE : ITER;
      end
      ITER: begin
        // Non-restoring step: sign of the partial remainder picks add vs subtract.
        shift     = 1'b1;
        add       = rem_msb;
        sub       = ~rem_msb;
        q0        = ~sum_msb;
        cntEnable = 1'b1;
        if (cntLast) nextState = CORRECT;
      end
      CORRECT: begin
        add       = rem_msb;
        nextState = SIGNFIX;
      end
      SIGNFIX: begin
        negate_q  = negQ;
        negate_r  = negR;
        nextState = DONE;
      end
      DONE: begin
        ready       = 1'b1;
        div_by_zero = zeroFlag;
        nextState   = IDLE;
      end
      default: nextState = IDLE;
    endcase
  end

  assign nop  = ~(add | sub | load);
  assign busy = (state != IDLE);

endmodule

// File: tb/tb_div_sequencer.sv
// tb/tb_div_sequencer.sv - directed table-driven bench for div_sequencer (WIDTH=8 and WIDTH=32)
module tb_div_sequencer;

  logic clock = 1'b0;
  logic reset = 1'b1;
  logic start8 = 1'b0;
  logic start32 = 1'b0;
  logic signed_mode = 1'b0;
  logic dividend_neg = 1'b0;
  logic divisor_neg = 1'b0;
  logic divisor_zero = 1'b0;
  logic rem_msb = 1'b0;
  logic sum_msb = 1'b0;

  logic load8, add8, sub8, shift8, q08, nop8, negq8, negr8, busy8, ready8, dbz8;
  logic [3:0] count8;
  logic load32, add32, sub32, shift32, q032, nop32, negq32, negr32, busy32, ready32, dbz32;
  logic [5:0] count32;

  logic [10:0] outs8;
  logic [10:0] outs32;
  assign outs8  = {load8, add8, sub8, shift8, q08, nop8, negq8, negr8, busy8, ready8, dbz8};
  assign outs32 = {load32, add32, sub32, shift32, q032, nop32, negq32, negr32, busy32, ready32, dbz32};

  always #5 clock = ~clock;

  div_sequencer #(.WIDTH(8)) dut8 (
    .clock(clock), .reset(reset), .start(start8), .signed_mode(signed_mode),
    .dividend_neg(dividend_neg), .divisor_neg(divisor_neg), .divisor_zero(divisor_zero),
    .rem_msb(rem_msb), .sum_msb(sum_msb), .load(load8), .add(add8), .sub(sub8),
    .shift(shift8), .q0(q08), .nop(nop8), .negate_q(negq8), .negate_r(negr8),
    .busy(busy8), .ready(ready8), .div_by_zero(dbz8), .count(count8)
  );

  div_sequencer #(.WIDTH(32)) dut32 (
    .clock(clock), .reset(reset), .start(start32), .signed_mode(signed_mode),
    .dividend_neg(dividend_neg), .divisor_neg(divisor_neg), .divisor_zero(divisor_zero),
    .rem_msb(rem_msb), .sum_msb(sum_msb), .load(load32), .add(add32), .sub(sub32),
    .shift(shift32), .q0(q032), .nop(nop32), .negate_q(negq32), .negate_r(negr32),
    .busy(busy32), .ready(ready32), .div_by_zero(dbz32), .count(count32)
  );

  // inputs: {start, signed_mode, dividend_neg, divisor_neg, divisor_zero, rem_msb, sum_msb}
  // outputs: {load, add, sub, shift, q0, nop, negate_q, negate_r, busy, ready, div_by_zero}
  typedef struct {
    logic [6:0]  in;
    logic [10:0] exp;
    logic [3:0]  cnt;
  } vec_t;

  vec_t vecs[30];
  int passed = 0;
  int total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic setv(input int i, input logic [6:0] in, input logic [10:0] e, input logic [3:0] c);
    vecs[i].in  = in;
    vecs[i].exp = e;
    vecs[i].cnt = c;
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  initial begin
    int loadCyc, readyCyc, shifts, busyBad, nReady, nLoads, found;
    int loadAt[4];

    // Signed op: dividend negative, divisor positive; CORRECT restores.
    setv( 0, 7'b1110000, 11'b00000100000, 4'd0);
    setv( 1, 7'b0000000, 11'b10000000100, 4'd0);
    setv( 2, 7'b0000001, 11'b00110000100, 4'd0);
    setv( 3, 7'b0000010, 11'b01011000100, 4'd1);
    setv( 4, 7'b0000011, 11'b01010000100, 4'd2);
    setv( 5, 7'b0000000, 11'b00111000100, 4'd3);
    setv( 6, 7'b0000000, 11'b00111000100, 4'd4);
    setv( 7, 7'b0000001, 11'b00110000100, 4'd5);
    setv( 8, 7'b0000011, 11'b01010000100, 4'd6);
    setv( 9, 7'b0000000, 11'b00111000100, 4'd7);
    setv(10, 7'b0000010, 11'b01000000100, 4'd8);
    setv(11, 7'b0000000, 11'b00000111100, 4'd8);
    setv(12, 7'b1000000, 11'b00000100110, 4'd8);
    // Unsigned op started on the IDLE cycle right after DONE; CORRECT is a nop.
    setv(13, 7'b1010000, 11'b00000100000, 4'd8);
    setv(14, 7'b0000000, 11'b10000000100, 4'd8);
    setv(15, 7'b0000000, 11'b00111000100, 4'd0);
    setv(16, 7'b0000011, 11'b01010000100, 4'd1);
    setv(17, 7'b0000001, 11'b00110000100, 4'd2);
    setv(18, 7'b0000010, 11'b01011000100, 4'd3);
    setv(19, 7'b0000000, 11'b00111000100, 4'd4);
    setv(20, 7'b0000000, 11'b00111000100, 4'd5);
    setv(21, 7'b0000000, 11'b00111000100, 4'd6);
    setv(22, 7'b0000000, 11'b00111000100, 4'd7);
    setv(23, 7'b0000001, 11'b00000100100, 4'd8);
    setv(24, 7'b0000000, 11'b00000100100, 4'd8);
    setv(25, 7'b0000000, 11'b00000100110, 4'd8);
    // Divide by zero: LOAD then DONE, no arithmetic or negate.
    setv(26, 7'b1110000, 11'b00000100000, 4'd8);
    setv(27, 7'b0000110, 11'b10000000100, 4'd8);
    setv(28, 7'b0000010, 11'b00000100111, 4'd0);
    setv(29, 7'b0000000, 11'b00000100000, 4'd0);

    // Reset state
    step();
    @(negedge clock);
    check("reset outs8", outs8, 11'b00000100000);
    check("reset count8", count8, 4'd0);
    check("reset outs32", outs32, 11'b00000100000);
    check("reset count32", count32, 6'd0);
    step();
    reset = 1'b0;

    // WIDTH=32 unsigned latency
    start32 = 1'b1;
    loadCyc = -1; readyCyc = -1; shifts = 0; busyBad = 0; nReady = 0;
    for (int cyc = 0; cyc <= 40; cyc++) begin
      @(negedge clock);
      if (load32 && loadCyc < 0) loadCyc = cyc;
      if (shift32) shifts++;
      if (ready32) begin
        nReady++;
        if (readyCyc < 0) readyCyc = cyc;
      end
      if (cyc >= 1 && cyc <= 35 && !busy32) busyBad++;
      if (cyc == 37) check("w32 busy after done", busy32, 1'b0);
      step();
      start32 = 1'b0;
    end
    check("w32 load cycle", loadCyc, 1);
    check("w32 shift count", shifts, 32);
    check("w32 ready cycle", readyCyc, 36);
    check("w32 ready pulses", nReady, 1);
    check("w32 busy gaps", busyBad, 0);

    // WIDTH=8 table
    for (int i = 0; i < 30; i++) begin
      {start8, signed_mode, dividend_neg, divisor_neg, divisor_zero, rem_msb, sum_msb} = vecs[i].in;
      @(negedge clock);
      check($sformatf("vec%0d outs", i), outs8, vecs[i].exp);
      check($sformatf("vec%0d count", i), count8, vecs[i].cnt);
      step();
    end
    {start8, signed_mode, dividend_neg, divisor_neg, divisor_zero, rem_msb, sum_msb} = 7'b0;

    // start held high: one op per WIDTH+5 cycles
    start8 = 1'b1;
    nLoads = 0; nReady = 0;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clock);
      if (load8) begin
        if (nLoads < 4) loadAt[nLoads] = cyc;
        nLoads++;
      end
      if (ready8) nReady++;
      step();
    end
    start8 = 1'b0;
    check("held loads", nLoads, 3);
    check("held ready pulses", nReady, 3);
    check("held first load", loadAt[0], 1);
    check("held spacing 1", loadAt[1] - loadAt[0], 13);
    check("held spacing 2", loadAt[2] - loadAt[1], 13);
    found = 0;
    for (int cyc = 0; cyc < 20 && found == 0; cyc++) begin
      @(negedge clock);
      if (!busy8) found = 1;
      step();
    end
    check("held returns idle", found, 1);

    // reset mid-ITER at count 5
    start8 = 1'b1;
    step();
    start8 = 1'b0;
    found = 0;
    for (int cyc = 0; cyc < 20 && found == 0; cyc++) begin
      @(negedge clock);
      if (shift8 && count8 == 4'd5) found = 1;
      else step();
    end
    check("reached count5", found, 1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    @(negedge clock);
    check("abort outs", outs8, 11'b00000100000);
    check("abort count", count8, 4'd0);
    nReady = 0;
    for (int cyc = 0; cyc < 5; cyc++) begin
      step();
      @(negedge clock);
      if (ready8 || busy8) nReady++;
    end
    check("abort quiet", nReady, 0);

    step();
    start8 = 1'b1;
    readyCyc = -1;
    for (int cyc = 0; cyc <= 15; cyc++) begin
      @(negedge clock);
      if (ready8 && readyCyc < 0) readyCyc = cyc;
      step();
      start8 = 1'b0;
    end
    check("post-reset ready cycle", readyCyc, 12);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
